// File: rtl/dma_ingress_packer_if.sv
// Stream-side bus of the DMA ingress packer: 32-bit AXI-Stream data beat with
// byte-granular keep and the packer's ready.
//   master : stream source (drives tdata/tkeep/tlast/tvalid, observes tready)
//   slave  : dma_ingress_packer (observes the beat, drives tready)
interface dma_ingress_packer_if;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/dma_ingress_packer.sv
// Packs an AXI-Stream byte stream into dense 32-bit words, zero-padding the
// last word of each packet, and buffers them in a first-word-fall-through FIFO
// that the DMA write engine reads directly.
// Optional feature macro: DMA_INGRESS_ERR_EN (sticky error flags + assertions).
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   s_axis        : stream input (slave modport of dma_ingress_packer_if)
//   o_fifo_empty  : no word available
//   o_fifo_rdata  : head word, valid while !o_fifo_empty (0 when empty)
//   i_fifo_ren    : pop head word
//   o_level       : words stored
//   o_pkt_valid   : one-cycle pulse after a packet's last word was written
//   o_pkt_len     : padded byte length of that packet, held until next pulse
//   o_err         : sticky flags {illegal tkeep, pop while empty}
module dma_ingress_packer #(
    parameter int unsigned DEPTH = 512
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dma_ingress_packer_if.slave     s_axis,
    output logic                    o_fifo_empty,
    output logic [31:0]             o_fifo_rdata,
    input  logic                    i_fifo_ren,
    output logic [$clog2(DEPTH):0]  o_level,
    output logic                    o_pkt_valid,
    output logic [31:0]             o_pkt_len,
    output logic [1:0]              o_err
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic {PACK, FLUSH} state_t;

    state_t        state, state_nxt;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [LW-1:0] level;
    logic          run;
    logic [1:0]    res_cnt, res_cnt_nxt;
    logic [23:0]   res_data, res_data_nxt;
    logic [31:0]   byte_cnt, byte_cnt_nxt;
    logic [31:0]   pkt_len_nxt, push_word;
    logic          push, pop, beat, pkt_done, not_full, keep_legal;
    logic [3:0]    keep_eff;
    logic [2:0]    k, sum;
    logic [31:0]   data_masked;
    logic [55:0]   packed_bytes;

    // run keeps tready low while in reset
    assign not_full      = level < LW'(DEPTH);
    assign s_axis.tready = run && (state == PACK) && not_full;
    assign beat          = s_axis.tvalid && s_axis.tready;
    assign pop           = i_fifo_ren && (level != '0);
    assign o_fifo_empty  = (level == '0);
    assign o_fifo_rdata  = o_fifo_empty ? 32'h0 : mem[rptr];
    assign o_level       = level;

    // Beat decode: illegal keep is treated as all four bytes valid
    always_comb begin
        keep_legal  = s_axis.tkeep inside {4'b0001, 4'b0011, 4'b0111, 4'b1111};
        keep_eff    = keep_legal ? s_axis.tkeep : 4'b1111;
        data_masked = '0;
        for (int i = 0; i < 4; i++) begin
            data_masked[i*8 +: 8] = keep_eff[i] ? s_axis.tdata[i*8 +: 8] : 8'h00;
        end
        case (keep_eff)
            4'b0001: k = 3'd1;
            4'b0011: k = 3'd2;
            4'b0111: k = 3'd3;
            default: k = 3'd4;
        endcase
        sum          = 3'(res_cnt) + k;
        // Beat bytes land directly above the residual bytes
        packed_bytes = 56'(res_data) | (56'(data_masked) << {res_cnt, 3'b000});
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= PACK;
        else        state <= state_nxt;
    end

    // Next-state, push and residual/byte-count updates
    always_comb begin
        state_nxt    = state;
        push         = 1'b0;
        push_word    = packed_bytes[31:0];
        res_cnt_nxt  = res_cnt;
        res_data_nxt = res_data;
        byte_cnt_nxt = byte_cnt;
        pkt_done     = 1'b0;
        pkt_len_nxt  = '0;
        case (state)
            PACK: begin
                if (beat) begin
                    byte_cnt_nxt = byte_cnt + 32'(k);
                    if (sum >= 3'd4) begin
                        push         = 1'b1;
                        res_cnt_nxt  = 2'(sum - 3'd4);
                        res_data_nxt = packed_bytes[55:32];
                    end else begin
                        res_cnt_nxt  = 2'(sum);
                        res_data_nxt = packed_bytes[23:0];
                    end
                    if (s_axis.tlast) begin
                        if (res_cnt_nxt == 2'd0) begin
                            pkt_done     = 1'b1;
                            pkt_len_nxt  = (byte_cnt_nxt + 32'd3) & ~32'd3;
                            byte_cnt_nxt = '0;
                        end else begin
                            state_nxt = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (not_full) begin
                    push         = 1'b1;
                    push_word    = {8'h00, res_data};
                    res_cnt_nxt  = 2'd0;
                    res_data_nxt = '0;
                    pkt_done     = 1'b1;
                    pkt_len_nxt  = (byte_cnt + 32'd3) & ~32'd3;
                    byte_cnt_nxt = '0;
                    state_nxt    = PACK;
                end
            end
            default: state_nxt = PACK;
        endcase
    end

    // Datapath and FIFO pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 1'b0;
            res_cnt     <= '0;
            res_data    <= '0;
            byte_cnt    <= '0;
            o_pkt_valid <= 1'b0;
            o_pkt_len   <= '0;
            wptr        <= '0;
            rptr        <= '0;
            level       <= '0;
        end else begin
            run         <= 1'b1;
            res_cnt     <= res_cnt_nxt;
            res_data    <= res_data_nxt;
            byte_cnt    <= byte_cnt_nxt;
            o_pkt_valid <= pkt_done;
            if (pkt_done) o_pkt_len <= pkt_len_nxt;
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage array, not reset: pointers and level define its contents
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_word;
    end

`ifdef DMA_INGRESS_ERR_EN
    logic [1:0] err;

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= '0;
        end else begin
            if (i_fifo_ren && (level == '0)) err[0] <= 1'b1;
            if (beat && !keep_legal)         err[1] <= 1'b1;
        end
    end

    assign o_err = err;

    a_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_fifo_ren && (level == '0)))
        else $error("dma_ingress_packer: pop while empty");

    a_bad_keep: assert property (@(posedge clk) disable iff (!rst_n)
        !(beat && !keep_legal))
        else $error("dma_ingress_packer: illegal tkeep");
`else
    assign o_err = 2'b00;
`endif

endmodule

// File: tb/tb_dma_ingress_packer.sv
// Directed self-checking bench for dma_ingress_packer (DEPTH = 4).
module tb_dma_ingress_packer;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;
    localparam int          TMO   = 50;

    logic          clk;
    logic          rst_n;
    logic          fifo_empty;
    logic [31:0]   fifo_rdata;
    logic          fifo_ren;
    logic [LW-1:0] level;
    logic          pkt_valid;
    logic [31:0]   pkt_len;
    logic [1:0]    err;

    int checks;
    int errors;

    dma_ingress_packer_if s_axis_if ();

    dma_ingress_packer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axis       (s_axis_if),
        .o_fifo_empty (fifo_empty),
        .o_fifo_rdata (fifo_rdata),
        .i_fifo_ren   (fifo_ren),
        .o_level      (level),
        .o_pkt_valid  (pkt_valid),
        .o_pkt_len    (pkt_len),
        .o_err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Offer one beat (called at posedge+1); returns cycles spent waiting for tready
    task automatic send_beat(input logic [31:0] d, input logic [3:0] kp, input logic lst,
                             output int waits);
        waits = 0;
        s_axis_if.tdata  = d;
        s_axis_if.tkeep  = kp;
        s_axis_if.tlast  = lst;
        s_axis_if.tvalid = 1'b1;
        while (!s_axis_if.tready && waits < TMO) begin
            @(posedge clk); #1;
            waits++;
        end
        if (waits >= TMO) check("beat_timeout", 32'(waits), 32'(0));
        @(posedge clk); #1;
        s_axis_if.tvalid = 1'b0;
        s_axis_if.tlast  = 1'b0;
    endtask

    // Check the head word, then pop it
    task automatic pop_check(input string tag, input logic [31:0] exp);
        check({tag, "_empty"}, 32'(fifo_empty), 32'(0));
        check(tag, fifo_rdata, exp);
        fifo_ren = 1'b1;
        @(posedge clk); #1;
        fifo_ren = 1'b0;
    endtask

    logic [31:0] exp_err;
    logic [31:0] words4 [8];
    int w, wsum;

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        fifo_ren = 1'b0;
        s_axis_if.tdata  = '0;
        s_axis_if.tkeep  = 4'hF;
        s_axis_if.tlast  = 1'b0;
        s_axis_if.tvalid = 1'b0;
        for (int i = 0; i < 8; i++) words4[i] = 32'hB000_0000 + 32'(i);

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_tready", 32'(s_axis_if.tready), 32'(0));
        check("rst_empty",  32'(fifo_empty), 32'(1));
        check("rst_rdata",  fifo_rdata, 32'h0);
        check("rst_level",  32'(level), 32'(0));
        check("rst_pvalid", 32'(pkt_valid), 32'(0));
        check("rst_plen",   pkt_len, 32'(0));
        check("rst_err",    32'(err), 32'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Full-word packet: one beat per cycle, no flush
        wsum = 0;
        send_beat(32'h11111111, 4'hF, 1'b0, w); wsum += w;
        send_beat(32'h22222222, 4'hF, 1'b0, w); wsum += w;
        send_beat(32'h33333333, 4'hF, 1'b0, w); wsum += w;
        send_beat(32'h44444444, 4'hF, 1'b1, w); wsum += w;
        check("full_waits",  32'(wsum), 32'(0));
        check("full_level",  32'(level), 32'(4));
        check("full_pvalid", 32'(pkt_valid), 32'(1));
        check("full_plen",   pkt_len, 32'd16);
        check("full_tready", 32'(s_axis_if.tready), 32'(0));
        pop_check("full_w0", 32'h11111111);
        check("full_pulse_end", 32'(pkt_valid), 32'(0));
        pop_check("full_w1", 32'h22222222);
        pop_check("full_w2", 32'h33333333);
        pop_check("full_w3", 32'h44444444);
        check("full_drained", 32'(fifo_empty), 32'(1));
        check("full_rdata0",  fifo_rdata, 32'h0);

        // Partial-beat packing with flush of a 3-byte residual
        send_beat(32'hAAAAAA01, 4'h1, 1'b0, w);
        check("part_lvl1", 32'(level), 32'(0));
        send_beat(32'hBBBB0302, 4'h3, 1'b0, w);
        check("part_lvl2", 32'(level), 32'(0));
        send_beat(32'h07060504, 4'hF, 1'b1, w);
        check("part_lvl3",   32'(level), 32'(1));
        check("part_flush",  32'(s_axis_if.tready), 32'(0));
        check("part_nopv",   32'(pkt_valid), 32'(0));
        @(posedge clk); #1;
        check("part_pvalid", 32'(pkt_valid), 32'(1));
        check("part_plen",   pkt_len, 32'd8);
        check("part_lvl4",   32'(level), 32'(2));
        pop_check("part_w0", 32'h04030201);
        pop_check("part_w1", 32'h00070605);

        // Back-pressure: fill to DEPTH, one pop admits exactly one more beat
        for (int i = 0; i < 4; i++) send_beat(32'hA0A0A0A0 + 32'(i), 4'hF, 1'b0, w);
        check("bp_level",  32'(level), 32'(4));
        check("bp_tready", 32'(s_axis_if.tready), 32'(0));
        s_axis_if.tdata  = 32'hA0A0A0A4;
        s_axis_if.tkeep  = 4'hF;
        s_axis_if.tvalid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("bp_hold_lvl", 32'(level), 32'(4));
        pop_check("bp_w0", 32'hA0A0A0A0);
        send_beat(32'hA0A0A0A4, 4'hF, 1'b0, w);
        check("bp_one_more", 32'(level), 32'(4));
        check("bp_tready2",  32'(s_axis_if.tready), 32'(0));
        for (int i = 1; i < 5; i++) pop_check("bp_w", 32'hA0A0A0A0 + 32'(i));
        send_beat(32'hA0A0A0A5, 4'hF, 1'b1, w);
        check("bp_plen", pkt_len, 32'd24);
        pop_check("bp_w5", 32'hA0A0A0A5);

        // Simultaneous push and pop: level stays <= 1, order preserved
        fork
            begin
                for (int i = 0; i < 8; i++) send_beat(words4[i], 4'hF, i == 7, w);
            end
            begin
                int idx, cyc;
                idx = 0;
                cyc = 0;
                while (idx < 8 && cyc < 100) begin
                    if (level > LW'(1)) check("pp_level", 32'(level), 32'(1));
                    if (!fifo_empty) begin
                        check("pp_word", fifo_rdata, words4[idx]);
                        idx++;
                        fifo_ren = 1'b1;
                    end else begin
                        fifo_ren = 1'b0;
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
                fifo_ren = 1'b0;
                check("pp_count", 32'(idx), 32'(8));
            end
        join
        check("pp_plen",  pkt_len, 32'd32);
        check("pp_empty", 32'(fifo_empty), 32'(1));

        // Error flags: pop on empty leaves FIFO untouched; illegal keep acts as 0xF
        fifo_ren = 1'b1;
        @(posedge clk); #1;
        fifo_ren = 1'b0;
        check("err_pop_lvl",   32'(level), 32'(0));
        check("err_pop_empty", 32'(fifo_empty), 32'(1));
        send_beat(32'h44332211, 4'b0101, 1'b1, w);
        check("err_plen", pkt_len, 32'd4);
        pop_check("err_word", 32'h44332211);
`ifdef DMA_INGRESS_ERR_EN
        exp_err = 32'd3;
`else
        exp_err = 32'd0;
`endif
        check("err_flags", 32'(err), exp_err);

        // Reset mid-packet: 2 stored words plus 3 residual bytes are discarded
        send_beat(32'hC0C0C0C0, 4'hF, 1'b0, w);
        send_beat(32'hC1C1C1C1, 4'hF, 1'b0, w);
        send_beat(32'h00332211, 4'h7, 1'b0, w);
        check("mid_level", 32'(level), 32'(2));
        rst_n = 1'b0;
        #3;
        check("mid_tready", 32'(s_axis_if.tready), 32'(0));
        check("mid_empty",  32'(fifo_empty), 32'(1));
        check("mid_rdata",  fifo_rdata, 32'h0);
        check("mid_lvl",    32'(level), 32'(0));
        check("mid_pvalid", 32'(pkt_valid), 32'(0));
        check("mid_plen",   pkt_len, 32'(0));
        check("mid_err",    32'(err), 32'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        send_beat(32'hFFFFFF5A, 4'h1, 1'b1, w);
        @(posedge clk); #1;
        check("post_plen", pkt_len, 32'd4);
        pop_check("post_word", 32'h0000005A);
        check("post_empty", 32'(fifo_empty), 32'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
